// File: rtl/vmem_responder.sv
// Single-outstanding memory responder: accepts one load/store, answers after
// LAT cycles and holds the response until the initiator consumes it.
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// WAIT  | request accepted, latency counter running down
// RESP  | response presented; held until rsp_valid && rsp_ready

module vmem_responder #(
   parameter int AW    = 8,
   parameter int DW    = 8,
   parameter int DEPTH = 256,
   parameter int LAT   = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_we,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int         IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q;
   logic          accept;
   logic          in_range;
   logic [IW-1:0] idx;
   logic          rsp_we_q, rsp_err_q;
   logic [DW-1:0] rsp_rdata_q;
   logic [DW-1:0] mem [DEPTH];

   assign in_range = (32'(req_addr) < DEPTH);
   assign idx      = req_addr[IW-1:0];

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               accept  = 1'b1;
               state_d = (LAT > 1) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd1) state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         rsp_we_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q       <= CNT_INIT;
            rsp_we_q    <= req_we;
            rsp_err_q   <= ~in_range;
            rsp_rdata_q <= (!req_we && in_range) ? mem[idx] : '0;
         end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   // Backing array is deliberately not reset; a store only lands on a real acceptance.
   always_ff @(posedge clk) begin
      if (accept && !rst && req_we && in_range) mem[idx] <= req_wdata;
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign rsp_we    = rsp_we_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_vmem_responder.sv
// Four responder instances with different LAT/DEPTH, exercised by directed and
// random transactions against an array-based memory model.

module tb_vmem_responder;

   localparam int N = 4;

   function automatic int lat_of(int g);
      case (g)
         0: return 2;
         1: return 1;
         2: return 3;
         default: return 15;
      endcase
   endfunction

   function automatic int depth_of(int g);
      return (g == 2) ? 16 : 256;
   endfunction

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_we, rsp_err, busy;
   logic [7:0]   req_addr [N];
   logic [7:0]   req_wdata [N];
   logic [7:0]   rsp_rdata [N];

   logic [7:0]   mdl   [N][256];
   bit           known [N][256];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      vmem_responder #(
         .AW(8), .DW(8), .DEPTH(depth_of(g)), .LAT(lat_of(g))
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_we    (req_we[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_we    (rsp_we[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g]),
         .busy      (busy[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full transaction on instance g; hold = cycles of rsp_ready=0 backpressure.
   task automatic txn(input int g, input bit we, input logic [7:0] a, input logic [7:0] d,
                      input int hold);
      int         n;
      bit         err, chk_data;
      logic [7:0] exp_rd;
      logic [7:0] rd0;
      err      = (int'(a) >= depth_of(g));
      chk_data = we || err || known[g][a];
      exp_rd   = (we || err) ? 8'h00 : mdl[g][a];

      @(negedge clk);
      req_valid[g] = 1'b1;
      req_we[g]    = we;
      req_addr[g]  = a;
      req_wdata[g] = d;
      rsp_ready[g] = (hold == 0);
      n = 0;
      while (!req_ready[g] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("accept_wait g%0d", g), n, 0);
      @(posedge clk);
      if (we && !err) begin
         mdl[g][a]   = d;
         known[g][a] = 1'b1;
      end
      @(negedge clk);
      req_valid[g] = 1'b0;
      if (lat_of(g) > 1) chk($sformatf("req_ready_wait g%0d", g), req_ready[g], 0);
      n = 0;
      while (!rsp_valid[g] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("latency g%0d", g), n, lat_of(g) - 1);
      chk($sformatf("rsp_we g%0d", g), rsp_we[g], we);
      chk($sformatf("rsp_err g%0d a%0h", g, a), rsp_err[g], err);
      if (chk_data) chk($sformatf("rsp_rdata g%0d a%0h", g, a), rsp_rdata[g], exp_rd);
      rd0 = rsp_rdata[g];
      if (hold > 0) begin
         // A second request presented during backpressure must be ignored.
         req_valid[g] = 1'b1;
         req_we[g]    = 1'b0;
         req_addr[g]  = 8'h00;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk($sformatf("hold_valid g%0d", g), rsp_valid[g], 1);
            chk($sformatf("hold_rdata g%0d", g), rsp_rdata[g], rd0);
            chk($sformatf("hold_err g%0d", g), rsp_err[g], err);
            chk($sformatf("hold_ready g%0d", g), req_ready[g], 0);
         end
         rsp_ready[g] = 1'b1;
      end
      @(negedge clk);
      req_valid[g] = 1'b0;
      chk($sformatf("consumed g%0d", g), rsp_valid[g], 0);
      chk($sformatf("idle_ready g%0d", g), req_ready[g], 1);
      chk($sformatf("idle_busy g%0d", g), busy[g], 0);
      rsp_ready[g] = 1'b0;
   endtask

   initial begin
      logic [7:0] pool [8];
      int         k;
      pool = '{8'h00, 8'h01, 8'h05, 8'h0F, 8'h10, 8'h20, 8'hFF, 8'h07};
      for (int g = 0; g < N; g++) begin
         req_valid[g] = 1'b0; req_we[g] = 1'b0; req_addr[g] = '0;
         req_wdata[g] = '0;   rsp_ready[g] = 1'b0;
         for (int a = 0; a < 256; a++) begin
            known[g][a] = 1'b0;
            mdl[g][a]   = '0;
         end
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
         chk($sformatf("rst_req_ready g%0d", g), req_ready[g], 1);
         chk($sformatf("rst_rsp_valid g%0d", g), rsp_valid[g], 0);
         chk($sformatf("rst_rsp_we g%0d", g), rsp_we[g], 0);
         chk($sformatf("rst_rsp_rdata g%0d", g), rsp_rdata[g], 0);
         chk($sformatf("rst_rsp_err g%0d", g), rsp_err[g], 0);
         chk($sformatf("rst_busy g%0d", g), busy[g], 0);
      end

      txn(0, 1'b1, 8'h05, 8'hA7, 0);
      txn(0, 1'b0, 8'h05, 8'h00, 0);
      txn(1, 1'b1, 8'h10, 8'h3C, 0);
      txn(1, 1'b0, 8'h10, 8'h00, 0);
      txn(1, 1'b1, 8'h10, 8'h3D, 0);
      txn(1, 1'b0, 8'h10, 8'h00, 0);
      txn(0, 1'b1, 8'hFF, 8'h80, 0);
      txn(0, 1'b0, 8'hFF, 8'h00, 5);
      txn(2, 1'b1, 8'h00, 8'h11, 0);
      txn(2, 1'b1, 8'h20, 8'hFF, 0);
      txn(2, 1'b0, 8'h00, 8'h00, 0);
      txn(2, 1'b0, 8'h10, 8'h00, 3);
      txn(3, 1'b1, 8'hFF, 8'h80, 0);
      txn(3, 1'b0, 8'hFF, 8'h00, 0);

      // Reset while instance 3 is counting down after an accepted store.
      @(negedge clk);
      req_valid[3] = 1'b1; req_we[3] = 1'b1; req_addr[3] = 8'h07; req_wdata[3] = 8'h55;
      @(posedge clk);
      mdl[3][8'h07]   = 8'h55;
      known[3][8'h07] = 1'b1;
      @(negedge clk);
      req_valid[3] = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_wait_busy", busy[3], 1);
      rst = 1'b1;
      #1;
      chk("rst_async_busy", busy[3], 0);
      chk("rst_async_rsp_valid", rsp_valid[3], 0);
      chk("rst_async_req_ready", req_ready[3], 1);
      @(negedge clk);
      rst = 1'b0;
      txn(3, 1'b0, 8'h07, 8'h00, 0);

      for (int g = 0; g < N; g++) begin
         for (int t = 0; t < 15; t++) begin
            k = $urandom_range(0, 8);
            txn(g, 1'($urandom_range(0, 1)),
                (k == 8) ? 8'($urandom) : pool[k],
                8'($urandom), $urandom_range(0, 2));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
